// File: rtl/sprite_mixer_pkg.sv
// Shared types and helpers for the sprite layer mixer: RGB565 pixel type,
// default transparent colour key and a constant-evaluable clog2.
package sprite_mixer_pkg;

  typedef logic [15:0] rgb565_t;

  localparam rgb565_t DEFAULT_KEY = 16'hF81F;

  // Usable in parameter expressions; clog2(1) returns 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sprite_ram.sv
// One sprite bitmap: 1W/1R synchronous RAM with a registered, read-first read port.
// Writes beyond DEPTH are dropped so a bad loader address cannot corrupt anything.
module sprite_ram #(
  parameter int DEPTH = 1750,
  parameter int AW    = 11,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;
  logic          wr_ok;

  assign wr_ok = we_i && ({1'b0, waddr_i} < DEPTH_W);

  // The read samples the array before this edge's write lands: read-first.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sprite_layer_mixer.sv
// N-channel sprite compositor on the pixel stream, fixed 3-cycle latency.
// Optional pixel-accurate ch0-vs-others collision flag: define SPRITE_COLLISION_EN.
module sprite_layer_mixer
  import sprite_mixer_pkg::*;
#(
  parameter int                N_CH   = 4,
  parameter int                PIX_W  = 16,
  parameter int                X_W    = 12,
  parameter int                SPR_W  = 50,
  parameter int                SPR_H  = 35,
  parameter logic [PIX_W-1:0]  KEY    = DEFAULT_KEY,
  localparam int               ADDR_W = clog2(SPR_W * SPR_H),
  localparam int               CH_W   = (N_CH > 1) ? clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  pix_valid_i,
  input  logic [X_W-1:0]        pixel_x_i,
  input  logic [X_W-1:0]        pixel_y_i,
  input  logic [PIX_W-1:0]      bg_data_i,
  input  logic [N_CH*X_W-1:0]   sprite_x_i,
  input  logic [N_CH*X_W-1:0]   sprite_y_i,
  input  logic [N_CH-1:0]       sprite_en_i,
  input  logic                  load_en_i,
  input  logic [CH_W-1:0]       load_ch_i,
  input  logic [ADDR_W-1:0]     load_addr_i,
  input  logic [PIX_W-1:0]      load_data_i,
  output logic                  pix_valid_o,
  output logic [PIX_W-1:0]      pixel_o,
  output logic [N_CH-1:0]       hit_o,
  output logic                  collision_o
);

  localparam logic [X_W:0] SPR_W_X = (X_W + 1)'(SPR_W);
  localparam logic [X_W:0] SPR_H_X = (X_W + 1)'(SPR_H);

  // Shadow position/enable, only updated on frame_start so sprites never tear.
  logic [N_CH*X_W-1:0] sx_q;
  logic [N_CH*X_W-1:0] sy_q;
  logic [N_CH-1:0]     en_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q <= '0;
    end else if (frame_start) begin
      sx_q <= sprite_x_i;
      sy_q <= sprite_y_i;
      en_q <= sprite_en_i;
    end
  end

  logic [N_CH-1:0]  inside_d;
  logic [N_CH-1:0]  opaque;
  logic [PIX_W-1:0] s2_data [N_CH];

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : gen_ch
      logic [X_W:0]        dx;
      logic [X_W:0]        dy;
      logic [ADDR_W-1:0]   addr_d;
      logic [ADDR_W-1:0]   addr_q;
      logic                we;

      // The extra MSB is the borrow: a scan left of/above the sprite makes
      // dx/dy huge, so the range compare alone rejects it and nothing wraps.
      assign dx = {1'b0, pixel_x_i} - {1'b0, sx_q[gi*X_W +: X_W]};
      assign dy = {1'b0, pixel_y_i} - {1'b0, sy_q[gi*X_W +: X_W]};

      assign inside_d[gi] = pix_valid_i && en_q[gi] && !dx[X_W] && !dy[X_W] &&
                            (dx < SPR_W_X) && (dy < SPR_H_X);

      assign addr_d = inside_d[gi] ?
                      (ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(dx)) : '0;

      always_ff @(posedge clk) begin
        addr_q <= addr_d;
      end

      // Channel indices at or above N_CH match no instance and are dropped.
      assign we = load_en_i && (load_ch_i == CH_W'(gi));

      sprite_ram #(
        .DEPTH (SPR_W * SPR_H),
        .AW    (ADDR_W),
        .DW    (PIX_W)
      ) u_ram (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (load_addr_i),
        .wdata_i (load_data_i),
        .raddr_i (addr_q),
        .rdata_o (s2_data[gi])
      );
    end
  endgenerate

  logic              s1_valid_q;
  logic [PIX_W-1:0]  s1_bg_q;
  logic [N_CH-1:0]   s1_inside_q;
  logic              s2_valid_q;
  logic [PIX_W-1:0]  s2_bg_q;
  logic [N_CH-1:0]   s2_inside_q;
  logic              pix_valid_q;
  logic [PIX_W-1:0]  pixel_q;
  logic [N_CH-1:0]   hit_q;
  logic [PIX_W-1:0]  pixel_d;
  logic [N_CH-1:0]   hit_d;

  for (gi = 0; gi < N_CH; gi++) begin : gen_opaque
    assign opaque[gi] = s2_inside_q[gi] && (s2_data[gi] != KEY);
  end

  // Scan from lowest priority upwards so the lowest opaque index wins.
  always_comb begin
    pixel_d = s2_bg_q;
    hit_d   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (opaque[i]) begin
        pixel_d  = s2_data[i];
        hit_d    = '0;
        hit_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_inside_q <= '0;
      s2_valid_q  <= 1'b0;
      s2_inside_q <= '0;
      pix_valid_q <= 1'b0;
      pixel_q     <= '0;
      hit_q       <= '0;
    end else begin
      s1_valid_q  <= pix_valid_i;
      s1_bg_q     <= bg_data_i;
      s1_inside_q <= inside_d;
      s2_valid_q  <= s1_valid_q;
      s2_bg_q     <= s1_bg_q;
      s2_inside_q <= s1_inside_q;
      pix_valid_q <= s2_valid_q;
      pixel_q     <= pixel_d;
      hit_q       <= hit_d;
    end
  end

  assign pix_valid_o = pix_valid_q;
  assign pixel_o     = pixel_q;
  assign hit_o       = hit_q;

`ifdef SPRITE_COLLISION_EN
  logic coll_now;
  logic flag_q;
  logic collision_q;

  assign coll_now = s2_valid_q && opaque[0] && (|(opaque >> 1));

  // A hit coinciding with frame_start belongs to the frame that is starting.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_q      <= 1'b0;
      collision_q <= 1'b0;
    end else if (frame_start) begin
      collision_q <= flag_q;
      flag_q      <= coll_now;
    end else if (coll_now) begin
      flag_q      <= 1'b1;
    end
  end

  assign collision_o = collision_q;
`else
  assign collision_o = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_layer_mixer.sv
// Directed self-checking bench for sprite_layer_mixer (default parameters).
// Collision expectations follow SPRITE_COLLISION_EN when it is defined for the build.
module tb_sprite_layer_mixer;

`ifdef SPRITE_COLLISION_EN
  localparam logic COLL = 1'b1;
`else
  localparam logic COLL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        pix_valid_i = 1'b0;
  logic [11:0] pixel_x_i = '0;
  logic [11:0] pixel_y_i = '0;
  logic [15:0] bg_data_i = '0;
  logic [47:0] sprite_x_i = '0;
  logic [47:0] sprite_y_i = '0;
  logic [3:0]  sprite_en_i = '0;
  logic        load_en_i = 1'b0;
  logic [1:0]  load_ch_i = '0;
  logic [10:0] load_addr_i = '0;
  logic [15:0] load_data_i = '0;
  logic        pix_valid_o;
  logic [15:0] pixel_o;
  logic [3:0]  hit_o;
  logic        collision_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sprite_layer_mixer dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .pix_valid_i (pix_valid_i),
    .pixel_x_i   (pixel_x_i),
    .pixel_y_i   (pixel_y_i),
    .bg_data_i   (bg_data_i),
    .sprite_x_i  (sprite_x_i),
    .sprite_y_i  (sprite_y_i),
    .sprite_en_i (sprite_en_i),
    .load_en_i   (load_en_i),
    .load_ch_i   (load_ch_i),
    .load_addr_i (load_addr_i),
    .load_data_i (load_data_i),
    .pix_valid_o (pix_valid_o),
    .pixel_o     (pixel_o),
    .hit_o       (hit_o),
    .collision_o (collision_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic fill(input int ch, input logic [15:0] d);
    for (int a = 0; a < 1750; a++) begin
      @(negedge clk);
      load_en_i   = 1'b1;
      load_ch_i   = ch[1:0];
      load_addr_i = a[10:0];
      load_data_i = d;
    end
    @(negedge clk);
    load_en_i = 1'b0;
    $display("load ch%0d <= %h x1750", ch, d);
  endtask

  task automatic load_one(input int ch, input int addr, input logic [15:0] d);
    @(negedge clk);
    load_en_i   = 1'b1;
    load_ch_i   = ch[1:0];
    load_addr_i = addr[10:0];
    load_data_i = d;
    @(negedge clk);
    load_en_i = 1'b0;
    $display("load ch%0d[%0d] <= %h", ch, addr, d);
  endtask

  task automatic set_pos(input int ch, input int x, input int y, input logic en);
    sprite_x_i[ch*12 +: 12] = x[11:0];
    sprite_y_i[ch*12 +: 12] = y[11:0];
    sprite_en_i[ch]         = en;
  endtask

  task automatic frame(input logic exp_coll, input string tag);
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    $display("frame_start  collision_o=%0b", collision_o);
    check(tag, 32'(collision_o), 32'(exp_coll));
  endtask

  // One pixel in, result checked exactly 3 clocks later (and not earlier).
  task automatic scan(input string tag, input int x, input int y, input logic [15:0] bg,
                      input logic [15:0] exp_pix, input logic [3:0] exp_hit);
    @(negedge clk);
    pixel_x_i   = x[11:0];
    pixel_y_i   = y[11:0];
    bg_data_i   = bg;
    pix_valid_i = 1'b1;
    @(negedge clk);
    pix_valid_i = 1'b0;
    @(negedge clk);
    check({tag, ".early"}, 32'(pix_valid_o), 32'(0));
    @(negedge clk);
    $display("scan (%0d,%0d) bg=%h -> valid=%0b pixel=%h hit=%b", x, y, bg, pix_valid_o, pixel_o, hit_o);
    check({tag, ".valid"}, 32'(pix_valid_o), 32'(1));
    check({tag, ".pixel"}, 32'(pixel_o), 32'(exp_pix));
    check({tag, ".hit"}, 32'(hit_o), 32'(exp_hit));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst.valid", 32'(pix_valid_o), 32'(0));
    check("rst.pixel", 32'(pixel_o), 32'(0));
    check("rst.hit", 32'(hit_o), 32'(0));
    check("rst.coll", 32'(collision_o), 32'(0));
    rst = 1'b0;

    fill(0, 16'h07E0);
    fill(1, 16'h001F);
    fill(2, 16'hFFE0);

    // Single sprite, edges and clipping.
    set_pos(0, 100, 100, 1'b1);
    frame(1'b0, "t1.coll");
    scan("t1.in",     100, 100, 16'h1234, 16'h07E0, 4'b0001);
    scan("t1.right",  150, 100, 16'h1234, 16'h1234, 4'b0000);
    scan("t1.left",    99, 100, 16'h2345, 16'h2345, 4'b0000);
    scan("t1.corner", 149, 134, 16'h1234, 16'h07E0, 4'b0001);
    scan("t1.below",  100, 135, 16'h3456, 16'h3456, 4'b0000);

    // Priority, transparency, read-first.
    set_pos(1, 100, 100, 1'b1);
    frame(1'b0, "t2.coll");
    scan("t2.prio", 100, 100, 16'h1111, 16'h07E0, 4'b0001);
    load_one(0, 0, 16'hF81F);
    scan("t2.key",  100, 100, 16'h1111, 16'h001F, 4'b0010);

    @(negedge clk);
    pixel_x_i   = 12'd101;
    pixel_y_i   = 12'd100;
    bg_data_i   = 16'h2222;
    pix_valid_i = 1'b1;
    @(negedge clk);
    pix_valid_i = 1'b0;
    load_en_i   = 1'b1;
    load_ch_i   = 2'd0;
    load_addr_i = 11'd1;
    load_data_i = 16'h0F0F;
    @(negedge clk);
    load_en_i = 1'b0;
    @(negedge clk);
    $display("read-first (101,100) -> pixel=%h hit=%b", pixel_o, hit_o);
    check("t2.rdfirst", 32'(pixel_o), 32'h07E0);
    scan("t2.newdata", 101, 100, 16'h2222, 16'h0F0F, 4'b0001);

    // Right-edge clipping without wrap.
    set_pos(2, 4080, 200, 1'b1);
    frame(COLL, "t3.coll");
    scan("t3.nowrap", 5,    200, 16'h4444, 16'h4444, 4'b0000);
    scan("t3.edge",   4095, 200, 16'h4444, 16'hFFE0, 4'b0100);

    // Mid-frame position change waits for frame_start.
    set_pos(2, 10, 200, 1'b1);
    scan("t4.old",    4095, 200, 16'h5555, 16'hFFE0, 4'b0100);
    scan("t4.notyet", 10,   200, 16'h5555, 16'h5555, 4'b0000);
    frame(1'b0, "t4.coll");
    scan("t4.new",    10,   200, 16'h5555, 16'hFFE0, 4'b0100);
    scan("t4.gone",   4095, 200, 16'h5555, 16'h5555, 4'b0000);

    // One-pixel ch0/ch2 overlap.
    set_pos(1, 100, 100, 1'b0);
    set_pos(2, 149, 134, 1'b1);
    frame(1'b0, "t5.coll0");
    scan("t5.ovl",  149, 134, 16'h6666, 16'h07E0, 4'b0001);
    scan("t5.ch2",  150, 134, 16'h6666, 16'hFFE0, 4'b0100);
    frame(COLL, "t5.coll1");
    frame(1'b0, "t5.coll2");

    // Reset mid-stream.
    @(negedge clk);
    pixel_x_i   = 12'd149;
    pixel_y_i   = 12'd134;
    bg_data_i   = 16'h7777;
    pix_valid_i = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("rst pulse -> valid=%0b pixel=%h hit=%b", pix_valid_o, pixel_o, hit_o);
    check("t6.valid0", 32'(pix_valid_o), 32'(0));
    check("t6.pixel0", 32'(pixel_o), 32'(0));
    check("t6.hit0", 32'(hit_o), 32'(0));
    check("t6.coll0", 32'(collision_o), 32'(0));
    @(negedge clk);
    check("t6.valid1", 32'(pix_valid_o), 32'(0));
    @(negedge clk);
    check("t6.valid2", 32'(pix_valid_o), 32'(0));
    @(negedge clk);
    pix_valid_i = 1'b0;
    $display("after rst -> valid=%0b pixel=%h hit=%b", pix_valid_o, pixel_o, hit_o);
    check("t6.valid3", 32'(pix_valid_o), 32'(1));
    check("t6.hidden", 32'(pixel_o), 32'h7777);
    check("t6.hidhit", 32'(hit_o), 32'(0));
    frame(1'b0, "t6.coll");
    scan("t6.back", 149, 134, 16'h7777, 16'h07E0, 4'b0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
